// File: rtl/popcount_frame_accum.sv
`default_nettype none
// ============================================================================
// popcount_frame_accum
//   Sums the set bits of streamed words over frames and hands out frame totals.
//   Rev 1.0
// ============================================================================
module popcount_frame_accum #(
  parameter int DW        = 8,
  parameter int FRAME_LEN = 4,
  parameter int CW        = $clog2(DW + 1),
  parameter int SW        = $clog2(DW * FRAME_LEN + 1),
  parameter int NW        = $clog2(FRAME_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  output logic          sum_valid_o,
  input  logic          sum_ready_i,
  output logic [SW-1:0] sum_o,
  output logic [NW-1:0] words_o
);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam logic [NW-1:0] C_LAST_IDX = NW'(FRAME_LEN - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [NW-1:0] words_q, words_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] w_pop;
  logic [SW-1:0] w_acc_next;

  // CW is wide enough to hold DW itself, so an all-ones word never wraps.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DW; i++) begin
      w_pop = w_pop + CW'(data_i[i]);
    end
  end

  assign w_acc_next = acc_q + SW'(w_pop);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    words_d = words_q;
    valid_d = valid_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          // A last_i that coincides with the final slot is one frame end.
          if (last_i || (cnt_q == C_LAST_IDX)) begin
            sum_d   = w_acc_next;
            words_d = cnt_q + NW'(1);
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b1;
            state_d = ST_OUT;
          end else begin
            acc_d = w_acc_next;
            cnt_d = cnt_q + NW'(1);
          end
        end
      end
      ST_OUT: begin
        if (sum_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      words_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      words_q <= words_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready    = (state_q == ST_ACC);
  assign sum_valid_o = valid_q;
  assign sum_o       = sum_q;
  assign words_o     = words_q;

endmodule
`default_nettype wire
